// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : wb_regfile
// Purpose  : 32 x 32-bit register file with a write-back source mux. It has
//            two combinational read ports and a counter of committed writes.
//            Register 0 is hard-wired to zero.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports    : clk            - single clock, rising edge
//            rst_n          - asynchronous active-low reset
//            WB_RegWrite    - write-back request
//            WB_WriteReg    - destination register index
//            WB_RegSrc      - write-data source (00 ALU, 01 mem, 10 PC+4,
//                             11 reserved)
//            WB_aluResult,
//            WB_dmOut,
//            WB_PC          - candidate write-data sources
//            rs_addr/rt_addr- read addresses
//            rs_data/rt_data- read data
//            wb_data        - selected write-back value (forwarding path)
//            wb_count       - number of committed writes (wraps silently)
// Config   : WB_BYPASS_EN   - when defined, a read that hits the register
//                             being committed this cycle returns wb_data
//                             instead of the old array contents.
// ============================================================================
module wb_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        WB_RegWrite,
    input  logic [4:0]  WB_WriteReg,
    input  logic [1:0]  WB_RegSrc,
    input  logic [31:0] WB_aluResult,
    input  logic [31:0] WB_dmOut,
    input  logic [31:0] WB_PC,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    output logic [31:0] wb_data,
    output logic [31:0] wb_count
);

    localparam logic [1:0]  c_SRC_ALU = 2'b00;
    localparam logic [1:0]  c_SRC_MEM = 2'b01;
    localparam logic [1:0]  c_SRC_PC4 = 2'b10;
    localparam logic [1:0]  c_SRC_RSV = 2'b11;
    localparam logic [4:0]  c_ZERO_REG = 5'd0;
    localparam logic [31:0] c_PC_STEP  = 32'd4;

    logic [31:0] r_regs [0:31];
    logic [31:0] r_wb_count;
    logic [31:0] w_wb_data;
    logic [31:0] w_rs_data;
    logic [31:0] w_rt_data;
    logic        w_commit;

    // Write-back source mux. The reserved encoding yields zero.
    always_comb begin
        w_wb_data = 32'h0;
        case (WB_RegSrc)
            c_SRC_ALU: w_wb_data = WB_aluResult;
            c_SRC_MEM: w_wb_data = WB_dmOut;
            c_SRC_PC4: w_wb_data = WB_PC + c_PC_STEP;
            default:   w_wb_data = 32'h0;
        endcase
    end

    // A write to r0 or one using the reserved source is dropped. It changes
    // neither the array nor the counter. The rst_n term keeps the bypass
    // path quiet during reset.
    assign w_commit = WB_RegWrite && (WB_WriteReg != c_ZERO_REG) &&
                      (WB_RegSrc != c_SRC_RSV) && rst_n;

    // Entry 0 is cleared on reset and never written, because w_commit
    // excludes it. The read mux also forces address 0 to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'h0;
            end
            r_wb_count <= 32'h0;
        end else if (w_commit) begin
            r_regs[WB_WriteReg] <= w_wb_data;
            r_wb_count          <= r_wb_count + 32'd1;
        end
    end

    always_comb begin
        w_rs_data = (rs_addr == c_ZERO_REG) ? 32'h0 : r_regs[rs_addr];
        w_rt_data = (rt_addr == c_ZERO_REG) ? 32'h0 : r_regs[rt_addr];
`ifdef WB_BYPASS_EN
        // w_commit already rules out WB_WriteReg == 0. A match therefore
        // never bypasses address 0.
        if (w_commit && (rs_addr == WB_WriteReg)) begin
            w_rs_data = w_wb_data;
        end
        if (w_commit && (rt_addr == WB_WriteReg)) begin
            w_rt_data = w_wb_data;
        end
`endif
    end

    assign rs_data  = w_rs_data;
    assign rt_data  = w_rt_data;
    assign wb_data  = w_wb_data;
    assign wb_count = r_wb_count;

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_regfile
// Purpose  : Directed self-checking bench for wb_regfile. Expected values are
//            hand-computed constants. Bypass expectations follow the
//            WB_BYPASS_EN build setting.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;

    logic        clk;
    logic        rst_n;
    logic        WB_RegWrite;
    logic [4:0]  WB_WriteReg;
    logic [1:0]  WB_RegSrc;
    logic [31:0] WB_aluResult;
    logic [31:0] WB_dmOut;
    logic [31:0] WB_PC;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] wb_data;
    logic [31:0] wb_count;

    int n_checks;
    int n_fail;

`ifdef WB_BYPASS_EN
    localparam logic [31:0] c_BYP_EXP = 32'hA5A5_A5A5;
`else
    localparam logic [31:0] c_BYP_EXP = 32'h0000_0001;
`endif

    wb_regfile dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .WB_RegWrite  (WB_RegWrite),
        .WB_WriteReg  (WB_WriteReg),
        .WB_RegSrc    (WB_RegSrc),
        .WB_aluResult (WB_aluResult),
        .WB_dmOut     (WB_dmOut),
        .WB_PC        (WB_PC),
        .rs_addr      (rs_addr),
        .rt_addr      (rt_addr),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .wb_data      (wb_data),
        .wb_count     (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one write-back request for a single rising edge.
    task automatic do_write(input logic we, input logic [4:0] r,
                            input logic [1:0] src, input logic [31:0] alu,
                            input logic [31:0] dm, input logic [31:0] pc);
        @(negedge clk);
        WB_RegWrite  = we;
        WB_WriteReg  = r;
        WB_RegSrc    = src;
        WB_aluResult = alu;
        WB_dmOut     = dm;
        WB_PC        = pc;
        @(posedge clk);
        #1;
        WB_RegWrite  = 1'b0;
    endtask

    task automatic read_both(input string tag, input logic [4:0] a,
                             input logic [31:0] exp);
        rs_addr = a;
        rt_addr = a;
        #1;
        check_eq({tag, "_rs"}, rs_data, exp);
        check_eq({tag, "_rt"}, rt_data, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        WB_RegWrite  = 1'b0;
        WB_WriteReg  = 5'd0;
        WB_RegSrc    = 2'b00;
        WB_aluResult = 32'h0;
        WB_dmOut     = 32'h0;
        WB_PC        = 32'h0;
        rs_addr      = 5'd0;
        rt_addr      = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        read_both("reset_r5", 5'd5, 32'h0);
        check_eq("reset_count", wb_count, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Write-data source selection.
        do_write(1'b1, 5'd5, 2'b00, 32'h0000_1234, 32'h1111_1111, 32'h2222_2222);
        do_write(1'b1, 5'd6, 2'b01, 32'h3333_3333, 32'hDEAD_BEEF, 32'h4444_4444);
        @(negedge clk);
        WB_RegSrc    = 2'b10;
        WB_PC        = 32'h0040_0000;
        #1;
        check_eq("wbdata_pc4", wb_data, 32'h0040_0004);
        do_write(1'b1, 5'd7, 2'b10, 32'h5555_5555, 32'h6666_6666, 32'h0040_0000);
        read_both("src_r5", 5'd5, 32'h0000_1234);
        read_both("src_r6", 5'd6, 32'hDEAD_BEEF);
        read_both("src_r7", 5'd7, 32'h0040_0004);
        check_eq("src_count", wb_count, 32'd3);
        do_write(1'b1, 5'd31, 2'b10, 32'h0, 32'h0, 32'hFFFF_FFFE);
        read_both("pc4_wrap_r31", 5'd31, 32'h0000_0002);
        check_eq("pc4_count", wb_count, 32'd4);

        // Writes to r0 and writes with the reserved source are dropped.
        do_write(1'b1, 5'd8, 2'b00, 32'h0000_0088, 32'h0, 32'h0);
        do_write(1'b1, 5'd0, 2'b00, 32'hFFFF_FFFF, 32'h0, 32'h0);
        read_both("zero_r0", 5'd0, 32'h0);
        check_eq("zero_count", wb_count, 32'd5);
        @(negedge clk);
        WB_RegSrc = 2'b11;
        #1;
        check_eq("wbdata_rsv", wb_data, 32'h0);
        do_write(1'b1, 5'd8, 2'b11, 32'hCAFE_0000, 32'hCAFE_0001, 32'hCAFE_0002);
        read_both("rsv_r8", 5'd8, 32'h0000_0088);
        check_eq("rsv_count", wb_count, 32'd5);

        // Bypass in the commit cycle.
        do_write(1'b1, 5'd9, 2'b00, 32'h0000_0001, 32'h0, 32'h0);
        @(negedge clk);
        WB_RegWrite  = 1'b1;
        WB_WriteReg  = 5'd9;
        WB_RegSrc    = 2'b00;
        WB_aluResult = 32'hA5A5_A5A5;
        rs_addr      = 5'd9;
        rt_addr      = 5'd9;
        #1;
        check_eq("byp_same_rs", rs_data, c_BYP_EXP);
        check_eq("byp_same_rt", rt_data, c_BYP_EXP);
        @(posedge clk);
        #1;
        WB_RegWrite = 1'b0;
        read_both("byp_next", 5'd9, 32'hA5A5_A5A5);
        check_eq("byp_count", wb_count, 32'd7);

        // No bypass without a write request.
        do_write(1'b1, 5'd9, 2'b00, 32'h0000_0001, 32'h0, 32'h0);
        @(negedge clk);
        WB_RegWrite  = 1'b0;
        WB_WriteReg  = 5'd9;
        WB_aluResult = 32'hA5A5_A5A5;
        rs_addr      = 5'd9;
        rt_addr      = 5'd9;
        #1;
        check_eq("gate_same_rs", rs_data, 32'h1);
        check_eq("gate_same_rt", rt_data, 32'h1);
        @(posedge clk);
        #1;
        read_both("gate_next", 5'd9, 32'h1);
        check_eq("gate_count", wb_count, 32'd8);

        // Counter wrap through a hierarchical preload.
        @(negedge clk);
        dut.r_wb_count = 32'hFFFF_FFFF;
        #1;
        check_eq("wrap_preload", wb_count, 32'hFFFF_FFFF);
        do_write(1'b1, 5'd10, 2'b01, 32'h0, 32'h0BAD_F00D, 32'h0);
        check_eq("wrap_count", wb_count, 32'h0);
        read_both("wrap_r10", 5'd10, 32'h0BAD_F00D);

        // Asynchronous reset in mid-cycle, with no clock edge.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        rs_addr = 5'd5;
        rt_addr = 5'd6;
        #1;
        check_eq("async_rs", rs_data, 32'h0);
        check_eq("async_rt", rt_data, 32'h0);
        check_eq("async_count", wb_count, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // A commit whose edge coincides with reset is lost.
        @(negedge clk);
        WB_RegWrite  = 1'b1;
        WB_WriteReg  = 5'd3;
        WB_RegSrc    = 2'b00;
        WB_aluResult = 32'h0000_0033;
        #4;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        WB_RegWrite = 1'b0;
        read_both("simul_r3", 5'd3, 32'h0);
        check_eq("simul_count", wb_count, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        do_write(1'b1, 5'd3, 2'b00, 32'h0000_0044, 32'h0, 32'h0);
        read_both("post_r3", 5'd3, 32'h0000_0044);
        check_eq("post_count", wb_count, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port WB_RegWrite, input, 1 bit: write-back request from the MEM/WB stage.
REQ-004 The block SHALL have port WB_WriteReg, input, 5 bits: destination register index.
REQ-005 The block SHALL have port WB_RegSrc, input, 2 bits: write-data source select.
REQ-006 The block SHALL have ports WB_aluResult, WB_dmOut and WB_PC, input, 32 bits each: candidate write-data sources.
REQ-007 The block SHALL have ports rs_addr and rt_addr, input, 5 bits each: read port addresses.
REQ-008 The block SHALL have ports rs_data and rt_data, output, 32 bits each: read port data.
REQ-009 The block SHALL have port wb_data, output, 32 bits: selected write-back value, used for forwarding.
REQ-010 The block SHALL have port wb_count, output, 32 bits: count of committed writes.

Function
REQ-011 wb_data SHALL be combinational, selected by WB_RegSrc:
- 00: WB_aluResult.
- 01: WB_dmOut.
- 10: WB_PC + 4, modulo 2^32.
- 11: 32'h0.
REQ-012 A commit SHALL occur on a rising clk edge when all of the following hold: WB_RegWrite=1, WB_WriteReg!=0, WB_RegSrc!=11, and rst_n=1.
REQ-013 On a commit, register[WB_WriteReg] SHALL take the value of wb_data; all other registers SHALL hold their values.
REQ-014 Register 0 SHALL read as 0 at all times, and writes to register 0 SHALL be discarded silently.
REQ-015 WB_RegSrc=11 with WB_RegWrite=1 SHALL be treated as reserved: no register write and no wb_count increment.
REQ-016 Read ports SHALL be combinational (zero latency) from the array: rs_data=register[rs_addr] and rt_data=register[rt_addr]. This is subject to REQ-022.
REQ-017 Both read ports SHALL be independent; rs_addr=rt_addr SHALL return identical data on both ports.
REQ-018 wb_count SHALL increment by 1 on each commit.
REQ-019 wb_count SHALL wrap from 32'hFFFFFFFF to 0 with no flag.
REQ-020 wb_count SHALL be registered; the new value is visible in the cycle after the commit edge.

Reset
REQ-021 While rst_n=0, the block SHALL immediately, without waiting for clk, clear:
- registers 1..31 to 32'h0;
- wb_count to 0.
rs_data and rt_data SHALL read 0 during reset; a commit in flight when rst_n falls SHALL be lost; the first commit is possible on the first rising clk edge with rst_n=1.

Configuration
REQ-022 Macro WB_BYPASS_EN SHALL control write-through bypass on the read ports.
- Defined: when a commit condition (REQ-012) holds in the current cycle and rs_addr or rt_addr equals WB_WriteReg, the matching read port SHALL return wb_data combinationally in that same cycle.
- Not defined: read ports SHALL return the pre-write array value until the edge, i.e. the old value in the commit cycle.
- In both cases, address 0 SHALL return 0.

Verification
REQ-023 Reset: assert rst_n=0 mid-cycle after registers are written -> all reads 0 and wb_count=0 immediately, with no clk edge.
REQ-024 Source select: write r5 with RegSrc=00/ALU=32'h1234, then r6 with RegSrc=01/dmOut=32'hDEAD_BEEF, then r7 with RegSrc=10/PC=32'h0040_0000 -> reads r5=32'h1234, r6=32'hDEAD_BEEF, r7=32'h0040_0004; wb_count=3.
REQ-025 Zero and reserved: write r0 with ALU=32'hFFFF_FFFF, and write r8 with RegSrc=11 -> r0=0, r8 unchanged, wb_count unchanged.
REQ-026 Bypass: in the commit cycle writing r9=32'hA5A5_A5A5 with rs_addr=rt_addr=9 and old r9=32'h1 -> both ports return 32'hA5A5_A5A5 with WB_BYPASS_EN defined, 32'h1 without it; both ports return 32'hA5A5_A5A5 in the next cycle in either build.
REQ-026a Bypass gating: repeat REQ-026 with WB_RegWrite=0 -> 32'h1 in both builds.
REQ-027 Wrap: force wb_count to 32'hFFFF_FFFF via repeated commits (or hierarchical preload), then one commit -> wb_count=0.
REQ-028 Simultaneous reset and commit: rst_n low on the same edge as a valid commit to r3 -> r3=0 and wb_count=0.
